// File: rtl/instr_exec_unit.sv
// instr_exec_unit: handshaked instruction decoder/executor with register file, ALU and flags.
// Optional build macro INSTR_EXEC_ILLEGAL_TRAP_EN: an illegal opcode halts the unit instead of acting as a NOP.
module instr_exec_unit #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    localparam int IW = 4 + 2*REG_AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IW-1:0]     id,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
    output logic              halted,
    output logic              illegal
);
`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       ir;
    logic [DATA_W-1:0]   regs [2**REG_AW];
    logic [3:0]          op;
    logic [REG_AW-1:0]   dst, src;
    logic [DATA_W-1:0]   imm, a, b;
    logic [DATA_W:0]     alu, alu_q;
    logic                we, we_q, ill, stop, wb_ill;

    assign op       = ir[IW-1 -: 4];
    assign dst      = ir[IW-5 -: REG_AW];
    assign src      = ir[IW-5-REG_AW -: REG_AW];
    assign imm      = ir[DATA_W-1:0];
    assign a        = regs[dst];
    assign b        = regs[src];
    assign stop     = (op == 4'b1000) || (TRAP && ill);
    assign wb_ill   = (state == S_WB) && ill;
    assign id_ready = state == S_IDLE;
    assign halted   = state == S_HALT;
    assign rd_data  = regs[rd_addr];

    // ALU: MSB of alu carries the carry-out/borrow; both operands are read before any write.
    always_comb begin
        alu = '0;
        we  = 1'b1;
        ill = 1'b0;
        case (op)
            4'b0001: alu = {1'b0, a} + {1'b0, b};
            4'b0011: alu = {1'b0, a} - {1'b0, b};
            4'b0100: alu = {1'b0, a & b};
            4'b0101: alu = {1'b0, a} + ONE;
            4'b0110: alu = {1'b0, a} - ONE;
            4'b0111: alu = {1'b0, a | b};
            4'b1001: alu = {1'b0, b};
            4'b1010: alu = {1'b0, a ^ b};
            4'b1100: alu = {1'b0, imm};
            4'b0000, 4'b1000: we = 1'b0;
            default: begin
                we  = 1'b0;
                ill = 1'b1;
            end
        endcase
    end

    // Next-state: accept in IDLE, fixed EXEC/WB sequence, HALT is terminal.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = id_valid ? S_EXEC : S_IDLE;
            S_EXEC:  state_nx = S_WB;
            S_WB:    state_nx = stop ? S_HALT : S_IDLE;
            default: state_nx = S_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Datapath: latch instruction, register ALU output, write back with flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir           <= '0;
            alu_q        <= '0;
            we_q         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            flag_n       <= 1'b0;
            illegal      <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
        end else begin
            result_valid <= (state == S_WB) && !stop;
            illegal      <= TRAP ? (illegal || wb_ill) : wb_ill;
            if (state == S_IDLE && id_valid) ir <= id;
            if (state == S_EXEC) begin
                alu_q <= alu;
                we_q  <= we;
            end
            if (state == S_WB && we_q) begin
                regs[dst] <= alu_q[DATA_W-1:0];
                result    <= alu_q[DATA_W-1:0];
                flag_z    <= alu_q[DATA_W-1:0] == '0;
                flag_c    <= alu_q[DATA_W];
                flag_n    <= alu_q[DATA_W-1];
            end
        end
    end
endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: randomized and directed checks of instr_exec_unit against a behavioural model.
module tb_instr_exec_unit;
    localparam int DW = 8, AW = 3, IW = 18, M = 256, NR = 8;
`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] id = '0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          id_ready, result_valid, flag_z, flag_c, flag_n, halted, illegal;
    logic [DW-1:0] rd_data, result;

    instr_exec_unit #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .id(id), .id_valid(id_valid), .id_ready(id_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .result(result), .result_valid(result_valid),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: architectural state plus one in-flight instruction whose effects land two edges after acceptance.
    int mr [NR] = '{default: 0};
    int m_res = 0, cnt = 0, m_acc = 0;
    bit m_z = 0, m_c = 0, m_n = 0, m_rv = 0, m_halt = 0, m_ill = 0, m_ready = 1;
    bit p_we, p_c, p_ill, p_halt;
    int p_val, p_dst, ma, mb, v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (mr[i]) mr[i] = 0;
            m_res = 0; cnt = 0; m_z = 0; m_c = 0; m_n = 0;
            m_rv = 0; m_halt = 0; m_ill = 0; m_ready = 1;
        end else begin
            m_rv = 0;
            if (!TRAP) m_ill = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (p_we) begin
                        mr[p_dst] = p_val; m_res = p_val;
                        m_z = p_val == 0; m_c = p_c; m_n = p_val >= M/2;
                    end
                    if (p_ill) m_ill = 1;
                    if (p_halt || (TRAP && p_ill)) m_halt = 1;
                    else begin m_rv = 1; m_ready = 1; end
                end
            end else if (m_ready && id_valid) begin
                p_dst = int'(id[13:11]);
                ma = mr[p_dst]; mb = mr[int'(id[10:8])];
                p_we = 1; p_c = 0; p_ill = 0; p_halt = 0; v = 0;
                case (int'(id[17:14]))
                    1:  begin v = ma + mb; p_c = v >= M; end
                    3:  begin v = ma - mb; p_c = ma < mb; end
                    4:  v = ma & mb;
                    5:  begin v = ma + 1; p_c = v >= M; end
                    6:  begin v = ma - 1; p_c = ma < 1; end
                    7:  v = ma | mb;
                    9:  v = mb;
                    10: v = ma ^ mb;
                    12: v = int'(id[7:0]);
                    0:  p_we = 0;
                    8:  begin p_we = 0; p_halt = 1; end
                    default: begin p_we = 0; p_ill = 1; end
                endcase
                p_val = v & (M - 1);
                cnt = 2; m_ready = 0; m_acc++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("id_ready", id_ready, m_ready);
        chk("result", result, m_res);
        chk("result_valid", result_valid, m_rv);
        chk("flag_z", flag_z, m_z);
        chk("flag_c", flag_c, m_c);
        chk("flag_n", flag_n, m_n);
        chk("halted", halted, m_halt);
        chk("illegal", illegal, m_ill);
        chk("rd_data", rd_data, mr[rd_addr]);
    end

    task automatic send(input int op, input int d, input int s, input int imm);
        int a0;
        bit ok;
        a0 = m_acc; ok = 0;
        id = {op[3:0], d[2:0], s[2:0], imm[7:0]};
        id_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            ok = m_acc != a0;
        end
        id_valid = 1'b0;
        id = 18'($urandom);
        chk("accept", 32'(ok), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic lit_reg(input int r, input int exp);
        @(posedge clk); #2;
        rd_addr = r[2:0];
        #1;
        chk($sformatf("R%0d", r), rd_data, exp);
    endtask

    task automatic lit_flags(input int res, input bit z, input bit c, input bit n);
        chk("lit_result", result, res);
        chk("lit_z", flag_z, z);
        chk("lit_c", flag_c, c);
        chk("lit_n", flag_n, n);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic lit_idle_outputs();
        chk("rst_ready", id_ready, 1);
        chk("rst_result", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_flags", {flag_z, flag_c, flag_n}, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
    endtask

    int snap [NR];
    int a0, op;

    initial begin
        do_reset();
        #1 lit_idle_outputs();
        for (int r = 0; r < NR; r++) lit_reg(r, 0);

        send(12, 5, 0, 'hF8);
        send(12, 6, 0, 'hCC);
        send(3, 5, 6, 0);
        lit_flags('h2C, 0, 0, 0);
        chk("rv_at_n2", result_valid, 1);
        @(posedge clk); #2;
        chk("rv_one_cycle", result_valid, 0);
        lit_reg(5, 'h2C);
        send(6, 5, 0, 0);
        send(6, 5, 0, 0);
        lit_flags('h2A, 0, 0, 0);
        lit_reg(5, 'h2A);
        send(12, 1, 0, 0);
        send(6, 1, 0, 0);
        lit_flags('hFF, 0, 1, 1);
        lit_reg(1, 'hFF);
        send(5, 1, 0, 0);
        lit_flags(0, 1, 1, 0);
        send(12, 3, 0, 'h81);
        send(3, 3, 3, 0);
        lit_flags(0, 1, 0, 0);
        send(12, 4, 0, 'hF0);
        send(1, 4, 6, 0);
        lit_flags('hBC, 0, 1, 1);

        @(posedge clk); #1;
        a0 = m_acc;
        id = {4'd5, 3'd7, 3'd0, 8'd0};
        id_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 id_valid = 1'b0;
        chk("b2b_accepts", m_acc - a0, 4);
        repeat (3) @(posedge clk);
        lit_reg(7, 4);

        repeat (600) begin
            @(posedge clk); #1;
            op = int'($urandom_range(0, 15));
            if (op == 8) op = 0;
            if (TRAP && !(op inside {0, 1, 3, 4, 5, 6, 7, 9, 10, 12})) op = 1;
            id = {op[3:0], 14'($urandom)};
            id_valid = 1'($urandom_range(0, 1));
            rd_addr = 3'($urandom);
        end
        id_valid = 1'b0;
        repeat (4) @(posedge clk);

        foreach (mr[i]) snap[i] = mr[i];
        send(8, 0, 0, 0);
        chk("halt_halted", halted, 1);
        chk("halt_ready", id_ready, 0);
        chk("halt_rv", result_valid, 0);
        id = {4'd12, 3'd0, 3'd0, 8'h77};
        id_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 id_valid = 1'b0;
        chk("halt_hold_halted", halted, 1);
        chk("halt_hold_ready", id_ready, 0);
        for (int r = 0; r < NR; r++) lit_reg(r, snap[r]);

        do_reset();
        send(15, 2, 0, 0);
        chk("ill_flag", illegal, 1);
        if (TRAP) begin
            chk("trap_halted", halted, 1);
            chk("trap_ready", id_ready, 0);
        end else begin
            chk("ill_halted", halted, 0);
            @(posedge clk); #2;
            chk("ill_pulse_end", illegal, 0);
            send(12, 2, 0, 'h3C);
            chk("post_ill_result", result, 'h3C);
            lit_reg(2, 'h3C);
        end

        do_reset();
        @(posedge clk); #1;
        a0 = m_acc;
        id = {4'd12, 3'd2, 3'd0, 8'h55};
        id_valid = 1'b1;
        @(posedge clk); #1;
        id_valid = 1'b0;
        chk("exec_accept", m_acc - a0, 1);
        #2 rst_n = 1'b0;
        #1 lit_idle_outputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        lit_reg(2, 0);
        #1 lit_idle_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

Parametrised successor to the 18-bit instruction decoder: it accepts one instruction per valid/ready handshake, decodes it, and executes it against an internal register file with a small ALU. It updates status flags and stops on HALT. It sits between the instruction source (bench or fetch logic) and downstream consumers of the result, flags and debug register read port.

## Interface
- `DATA_W`, default 8: register and immediate width; minimum 2.
- `REG_AW`, default 3: register address width, giving 2**REG_AW registers.
- `IW`, derived as 4 + 2*REG_AW + DATA_W (18 at defaults); not overridable.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id` in IW: instruction. Fields are `[IW-1:IW-4]` opcode, then dst (REG_AW), then src (REG_AW), then imm (DATA_W) in the LSBs.
- `id_valid` in 1: instruction present.
- `id_ready` out 1: unit can accept; equals (state==IDLE).
- `rd_addr` in REG_AW: debug read address.
- `rd_data` out DATA_W: combinational read of R[rd_addr].
- `result` out DATA_W: last written value.
- `result_valid` out 1: one-cycle pulse per retired instruction.
- `flag_z`, `flag_c`, `flag_n` out 1 each: zero, carry/borrow, and negative (MSB) flags.
- `halted` out 1: HALT executed.
- `illegal` out 1: undefined opcode seen.

## Operation
- Opcodes and their effects:
  - 0000 NOP: no register or flag update.
  - 0001 ADD: R[dst]=R[dst]+R[src].
  - 0011 SUB: R[dst]=R[dst]-R[src].
  - 0100 AND: R[dst]=R[dst]&R[src].
  - 0101 INC: R[dst]+1.
  - 0110 DEC: R[dst]-1.
  - 0111 OR: R[dst]=R[dst]|R[src].
  - 1000 HALT.
  - 1001 MOV: R[dst]=R[src].
  - 1010 XOR: R[dst]=R[dst]^R[src].
  - 1100 MOVI: R[dst]=imm.
  - All other opcodes are illegal.
- Arithmetic is DATA_W-bit modulo.
  - ADD/INC: `flag_c` = carry-out.
  - SUB/DEC: `flag_c` = borrow (1 when the unsigned minuend is less than the subtrahend).
  - Logic ops, MOV, MOVI: `flag_c` is cleared.
- Every register-writing op sets `flag_z` = (value==0) and `flag_n` = value[DATA_W-1]. NOP leaves all flags and `result` unchanged.
- FSM states: IDLE, EXEC, WB, HALT.
  - IDLE to EXEC on `id_valid && id_ready`; `id` is latched into an internal instruction register.
  - EXEC to WB unconditionally; the ALU output is registered.
  - WB to IDLE, except HALT goes from WB to HALT.
  - HALT is terminal: `id_ready`=0 and `halted`=1 until reset.
- `id_valid` outside IDLE is ignored. The `id` bus may change freely after acceptance.
- Same-register ops (dst==src) use the pre-instruction value for both operands; for example, SUB R3,R3 gives 0, Z=1, C=0.
- Reset values: all registers 0, `result`=0, `result_valid`=0, all flags 0, `halted`=0, `illegal`=0, state IDLE (so `id_ready`=1 once reset is released).
- Reset asserted in EXEC or WB aborts the instruction with no register write; all outputs return to their reset values immediately.

## Timing
- Handshake at edge N.
- Edge N+1: ALU result captured.
- Edge N+2: register write, `result`/flags update, and `result_valid`=1 for exactly the cycle after edge N+2. `id_ready` returns high in that same cycle.
- Throughput: one instruction per 3 cycles. Back-to-back `id_valid` is accepted at N, N+3, N+6, and so on.
- `rd_data` reflects a write from the cycle after edge N+2.
- HALT: `halted` rises after edge N+2 and `result_valid` stays 0.

## Configuration
- `INSTR_EXEC_ILLEGAL_TRAP_EN` defined: an illegal opcode sets `illegal`=1 at N+2 and enters HALT (`halted`=1, `id_ready`=0 until reset).
- Not defined: an illegal opcode executes as NOP; `illegal` pulses high for one cycle at N+2 and the unit returns to IDLE.
- In both modes an illegal opcode produces no register or flag update.

## Test plan
- Reset check: after reset deassert, expect `id_ready`=1, all outputs 0, and `rd_data`=0 for every address.
- MOVI R5,0xF8 then MOVI R6,0xCC then SUB R5,R6 (`id`=0011_101_110_xx): expect `result`=0x2C and R5=0x2C, with Z=0, C=0, N=0. `result_valid` pulses exactly 2 cycles after each handshake.
- DEC R5 twice: expect R5=0x2A. Then MOVI R1,0x00 and DEC R1: expect R1=0xFF with C=1 and N=1. Then INC R1: expect 0x00 with Z=1 and C=1.
- HALT (opcode 1000), then hold `id_valid`=1 for 10 cycles: expect `halted`=1 and `id_ready`=0, with no register changes.
- Opcode 1111: with the macro, expect `illegal`=1 and `halted`=1. Without it, expect a one-cycle `illegal` pulse and the next MOVI accepted normally.
- Hold `id_valid` high continuously: expect acceptance only every 3rd cycle. Assert reset during EXEC of MOVI R2,0x55: expect R2=0 and all outputs back to reset values.
